// File: rtl/hamming_tx_serializer_if.sv
// Byte handshake between the packet source and the Hamming(7,4) serializer.
// inj_pos exists only when HAMMING_TX_ERR_INJECT_EN is defined.
interface hamming_tx_serializer_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
`ifdef HAMMING_TX_ERR_INJECT_EN
   logic [2:0] inj_pos;
`endif

   modport master (
      output data_in,
      output data_valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
      output inj_pos,
`endif
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
      input  inj_pos,
`endif
      output data_ready
   );
endinterface

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) byte serializer: 16-bit-period frame (start, low cw, high cw, stop), 16*CLKS_PER_BIT+1 cycles per byte.
// data_ready only in IDLE with en; HAMMING_TX_ERR_INJECT_EN adds inj_pos to flip one low-codeword bit.
module hamming_tx_serializer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   hamming_tx_serializer_if.slave        bus,
   output logic                          tx_line,
   output logic                          tx_busy
);
   typedef enum logic [1:0] {IDLE, START, SEND, STOP} state_t;

   localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [3:0]  bidx, bidx_nxt;
   logic [13:0] shreg, shreg_nxt;
   logic        line_nxt, busy_nxt;
   logic        accept, wrap;
   logic [6:0]  cw_lo, cw_hi, flip;

   // Returns c[6:0]; c[0] is the first bit on the wire.
   function automatic logic [6:0] encode(input logic [3:0] d);
      return {d[3], d[2], d[1], d[3] ^ d[2] ^ d[1], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
   endfunction

   assign bus.data_ready = (state == IDLE) & en & ~rst;
   assign accept         = bus.data_valid & bus.data_ready;
   assign wrap           = (cnt == CNT_MAX);

   always_comb begin
      flip = 7'd0;
`ifdef HAMMING_TX_ERR_INJECT_EN
      if (bus.inj_pos != 3'd0) flip[bus.inj_pos - 3'd1] = 1'b1;
`endif
      cw_lo = encode(bus.data_in[3:0]) ^ flip;
      cw_hi = encode(bus.data_in[7:4]);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bidx_nxt  = bidx;
      shreg_nxt = shreg;
      line_nxt  = tx_line;
      busy_nxt  = tx_busy;
      if (state != IDLE) cnt_nxt = wrap ? 8'd0 : cnt + 8'd1;
      case (state)
         IDLE: begin
            line_nxt = 1'b1;
            busy_nxt = 1'b0;
            if (accept) begin
               state_nxt = START;
               cnt_nxt   = 8'd0;
               bidx_nxt  = 4'd0;
               shreg_nxt = {cw_hi, cw_lo};
               line_nxt  = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         START: begin
            if (wrap) begin
               state_nxt = SEND;
               line_nxt  = shreg[0];
               shreg_nxt = {1'b0, shreg[13:1]};
            end
         end
         SEND: begin
            if (wrap) begin
               if (bidx == 4'd13) begin
                  state_nxt = STOP;
                  line_nxt  = 1'b1;
               end else begin
                  bidx_nxt  = bidx + 4'd1;
                  line_nxt  = shreg[0];
                  shreg_nxt = {1'b0, shreg[13:1]};
               end
            end
         end
         STOP: begin
            if (wrap) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         bidx    <= 4'd0;
         shreg   <= 14'd0;
         tx_line <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bidx    <= bidx_nxt;
         shreg   <= shreg_nxt;
         tx_line <= line_nxt;
         tx_busy <= busy_nxt;
      end
   end
endmodule
